// File: rtl/set_counter_if.sv
// Job/result bundle for the set_counter coprocessor: start strobe with circle
// parameters in, busy/valid/count out.
interface set_counter_if;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  modport master (output en, central, radius, mode, input busy, valid, candidate);
  modport slave  (input en, central, radius, mode, output busy, valid, candidate);
endinterface

// File: rtl/set_counter.sv
// Scans an 8x8 lattice one point per clock and counts the points that satisfy
// a set relation between three circles A, B and C.
//
// state | meaning
// IDLE  | waiting for en; busy=0
// CALC  | scanning points (1,1)..(8,8), one per clock
// OUT   | one-cycle valid pulse; candidate holds the final count
module set_counter (
  input  logic          clk,
  input  logic          rst,
  set_counter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t      state, state_nxt;
  logic [23:0] cen_q;
  logic [11:0] rad_q;
  logic [2:0]  px, py;
  logic [6:0]  acc;
  logic [7:0]  cand_q;
  logic [3:0]  cx, cy;
  logic        a, b, c, hit, last, start;

  // Distances are folded to magnitudes first so the squares stay unsigned.
  function automatic logic in_circle(input logic [3:0] x, input logic [3:0] y,
                                     input logic [3:0] xc, input logic [3:0] yc,
                                     input logic [3:0] r);
    logic [4:0] dx, dy;
    logic [9:0] ax, ay, rr, sq;
    dx = {1'b0, x} - {1'b0, xc};
    dy = {1'b0, y} - {1'b0, yc};
    if (dx[4]) dx = -dx;
    if (dy[4]) dy = -dy;
    ax = {5'b0, dx};
    ay = {5'b0, dy};
    rr = {6'b0, r};
    sq = ax * ax + ay * ay;
    return sq <= rr * rr;
  endfunction

  always_comb begin
    cx    = {1'b0, px} + 4'd1;
    cy    = {1'b0, py} + 4'd1;
    a     = in_circle(cx, cy, cen_q[23:20], cen_q[19:16], rad_q[11:8]);
    b     = in_circle(cx, cy, cen_q[15:12], cen_q[11:8],  rad_q[7:4]);
    c     = in_circle(cx, cy, cen_q[7:4],   cen_q[3:0],   rad_q[3:0]);
    last  = (px == 3'd7) && (py == 3'd7);
    start = (state == IDLE) && bus.en;
    hit   = 1'b0;
    case (bus.mode)
      2'b00:   hit = a;
      2'b01:   hit = a | b;
      2'b10:   hit = a ^ b;
      default: hit = ((a & b) | (b & c) | (a & c)) & ~(a & b & c);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = CALC;
      CALC:    if (last)   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cen_q  <= '0;
      rad_q  <= '0;
      px     <= '0;
      py     <= '0;
      acc    <= '0;
      cand_q <= '0;
    end else if (start) begin
      cen_q <= bus.central;
      rad_q <= bus.radius;
      px    <= '0;
      py    <= '0;
      acc   <= '0;
    end else if (state == CALC) begin
      acc <= acc + {6'b0, hit};
      px  <= px + 3'd1;
      if (px == 3'd7) py <= py + 3'd1;
      // The last point's hit is folded in here so candidate never shows a partial count.
      if (last) cand_q <= {1'b0, acc + {6'b0, hit}};
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = (state == OUT);
  assign bus.candidate = cand_q;
endmodule

// File: tb/tb_set_counter.sv
// Scoreboard bench for set_counter: directed circle configurations with
// hand-computed counts, then back-to-back random jobs against a brute-force model.
module tb_set_counter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  typedef struct { int exp; int t0; } sb_t;
  sb_t sb[$];

  typedef struct { logic [23:0] cen; logic [11:0] rad; logic [1:0] mode; int exp; } vec_t;
  vec_t vecs[13];

  set_counter_if bus();
  set_counter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_c(int x, int y, logic [3:0] xc, logic [3:0] yc, logic [3:0] r);
    int dx, dy, rr;
    dx = x - int'(xc);
    dy = y - int'(yc);
    rr = int'(r);
    return (dx * dx + dy * dy) <= rr * rr;
  endfunction

  function automatic int model(logic [23:0] cen, logic [11:0] rad, logic [1:0] m);
    int n = 0;
    for (int y = 1; y <= 8; y++)
      for (int x = 1; x <= 8; x++) begin
        bit a, b, c, h;
        a = in_c(x, y, cen[23:20], cen[19:16], rad[11:8]);
        b = in_c(x, y, cen[15:12], cen[11:8],  rad[7:4]);
        c = in_c(x, y, cen[7:4],   cen[3:0],   rad[3:0]);
        case (m)
          2'b00: h = a;
          2'b01: h = a | b;
          2'b10: h = a ^ b;
          default: h = (int'(a) + int'(b) + int'(c)) == 2;
        endcase
        if (h) n++;
      end
    return n;
  endfunction

  // Caller is positioned at a negedge; the job is sampled on the next posedge.
  task automatic start_job(input logic [23:0] cen, input logic [11:0] rad,
                           input logic [1:0] m, input int exp, input bit push, input bit hold);
    sb_t e;
    bus.en      = 1'b1;
    bus.central = cen;
    bus.radius  = rad;
    bus.mode    = m;
    if (push) begin
      e.exp = exp;
      e.t0  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.central = 24'($urandom);
    bus.radius  = 12'($urandom);
    if (hold) begin
      @(posedge clk);
      #1;
    end
    bus.en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    vecs[0]  = '{24'h44_00_00, 12'h2_00, 2'b00, 13};
    vecs[1]  = '{24'h11_00_00, 12'h0_00, 2'b00, 1};
    vecs[2]  = '{24'hFF_00_00, 12'h1_00, 2'b00, 0};
    vecs[3]  = '{24'h44_00_00, 12'hF_00, 2'b00, 64};
    vecs[4]  = '{24'h88_00_00, 12'hF_00, 2'b00, 64};
    vecs[5]  = '{24'h00_00_00, 12'h2_00, 2'b00, 1};
    vecs[6]  = '{24'h33_66_00, 12'h2_20, 2'b01, 26};
    vecs[7]  = '{24'h33_66_00, 12'h2_20, 2'b10, 26};
    vecs[8]  = '{24'h44_54_00, 12'h1_10, 2'b01, 8};
    vecs[9]  = '{24'h44_54_00, 12'h1_10, 2'b10, 6};
    vecs[10] = '{24'h44_44_44, 12'h2_22, 2'b11, 0};
    vecs[11] = '{24'h44_44_FF, 12'h2_21, 2'b11, 13};
    vecs[12] = '{24'h44_54_44, 12'h1_10, 2'b11, 1};

    rst = 1'b0;
    bus.en = 1'b0;
    bus.central = '0;
    bus.radius = '0;
    bus.mode = 2'b00;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (prev_valid) begin
            check("valid_one_cycle", bus.valid, 0);
            check("busy_after_out", bus.busy, 0);
          end
          if (bus.valid) begin
            check("valid_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              sb_t e;
              e = sb.pop_front();
              check("candidate", bus.candidate, e.exp);
              check("latency_le_66", (cyc - e.t0) <= 66, 1);
            end
          end
          prev_valid = bus.valid;
        end else begin
          prev_valid = 1'b0;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_candidate", bus.candidate, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_busy", bus.busy, 0);

    for (int i = 0; i < 13; i++) begin
      start_job(vecs[i].cen, vecs[i].rad, vecs[i].mode, vecs[i].exp, 1'b1, (i % 2) == 1);
      wait_idle("directed");
    end

    // Abort: reset mid-job clears outputs and produces no valid pulse.
    start_job(24'h44_00_00, 12'hF_00, 2'b00, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.valid, 0);
    check("abort_candidate", bus.candidate, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (70) @(negedge clk);
    check("abort_idle", bus.busy, 0);

    for (int j = 0; j < 64; j++) begin
      logic [23:0] cen;
      logic [11:0] rad;
      logic [1:0]  m;
      cen = 24'($urandom);
      rad = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
      m   = 2'($urandom_range(0, 3));
      start_job(cen, rad, m, model(cen, rad, m), 1'b1, (j % 4) == 0);
      wait_idle("random");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
